rs_unified: RTL
===============

# rs_unified

Parametrised unified reservation station for the out-of-order core. It sits between dispatch and the functional units. Any entry can hold any FU type, and the station wakes operands from `NUM_CDB` common data buses. Each cycle it issues at most one ready instruction per FU type over a valid/ready handshake, then frees the entry on acceptance. On branch mispredict it selectively squashes entries younger than the branch.

## Interface
Parameters:
- `NUM_ENTRIES`, 8, number of entries, ≥2
- `ENT_IDX_W`, $clog2(NUM_ENTRIES), entry index width
- `ROB_TAG_W`, 5, ROB tag width; the ROB is 2^ROB_TAG_W deep
- `DATA_W`, 32, operand width
- `NUM_CDB`, 2, number of CDB broadcast ports
- `NUM_FU`, 4, number of FU types (ALU=0, LOAD=1, STORE=2, MULT=3)
- `FU_W`, $clog2(NUM_FU), FU select width
- `PAYLOAD_W`, 64, opaque decoded-instruction payload width

Ports (clock and reset: reset reset, asynchronous, active-high; clock clock):
- `clock` in 1 system clock
- `reset` in 1 asynchronous active-high reset
- `dp_valid` in 1 dispatch request
- `dp_ready` out 1 station can accept a dispatch
- `dp_fu` in FU_W target FU type
- `dp_rob_tag` in ROB_TAG_W destination ROB tag
- `dp_src_ready` in 2 per-operand: value already valid
- `dp_src_tag` in 2×ROB_TAG_W per-operand producer tag
- `dp_src_value` in 2×DATA_W per-operand value, used when ready
- `dp_payload` in PAYLOAD_W decoded instruction
- `cdb_valid` in NUM_CDB broadcast valid
- `cdb_tag` in NUM_CDB×ROB_TAG_W broadcast tag
- `cdb_value` in NUM_CDB×DATA_W broadcast value
- `rob_head` in ROB_TAG_W oldest ROB tag, used for age compare
- `squash_valid` in 1 mispredict squash
- `squash_tag` in ROB_TAG_W mispredicted branch tag
- `flush_all` in 1 clear every entry
- `iss_valid` out NUM_FU per-FU issue valid
- `iss_ready` in NUM_FU per-FU accept
- `iss_rob_tag` out NUM_FU×ROB_TAG_W issued ROB tag
- `iss_v1`, `iss_v2` out NUM_FU×DATA_W operands
- `iss_payload` out NUM_FU×PAYLOAD_W payload
- `free_count` out ENT_IDX_W+1 number of free entries

## Operation
- Each entry holds: valid, fu, rob_tag, rdy[2], tag[2], val[2], payload.
- **Allocation.** `dp_ready = free_count != 0` and not `squash_valid` and not `flush_all`.
  - On `dp_valid && dp_ready` the lowest-index free entry is written.
  - An operand with `dp_src_ready=0` whose tag matches a valid CDB that cycle is written ready with the CDB value (same-cycle capture).
- **Wakeup.** Every valid, not-ready operand whose tag matches a valid CDB port latches that value and sets rdy.
  - If more than one CDB port matches, the lowest port index wins. Matching ports should not occur.
- **Select.** For each FU type f, the candidates are entries with valid, fu==f and both rdy.
  - `iss_valid[f]` is set if any candidate exists. The issue outputs carry the selected entry.
  - The selected entry is held stable until `iss_ready[f]`.
- **Issue.** `iss_valid[f] && iss_ready[f]` clears that entry at the edge. Up to NUM_FU entries can free per cycle.
- **Squash.** Age is `(tag - rob_head) mod 2^ROB_TAG_W`.
  - `squash_valid` clears every entry whose age is greater than the age of `squash_tag`.
  - `flush_all` clears every entry.
  - The branch's own entry is kept.
- **Priority per edge:** flush_all > squash > issue-free > wakeup/allocate.
  - A freed entry is not reallocated in the same cycle.
  - An issue accepted during a squash still completes at the FU; the entry is cleared either way.

## Timing
- **Reset values:** all entries invalid; `iss_valid=0`; `free_count=NUM_ENTRIES`; `dp_ready=0` while reset is high and 1 after it is released.
- **Dispatch to issue:** an entry dispatched with both operands ready asserts `iss_valid` the next cycle, a minimum latency of 1.
- **CDB to issue:** a CDB broadcast at edge N makes the entry issuable in cycle N+1. There is no same-cycle wakeup-to-issue.
- **Outputs:** all outputs are combinational from registered state, except `dp_ready`, which also depends on `squash_valid` and `flush_all`.
- **Full:** when `free_count==0`, `dp_ready=0`. A simultaneous issue does not make space until the next cycle.
- **Tag wrap:** ROB tags wrap modulo 2^ROB_TAG_W. The age compare is valid for up to 2^ROB_TAG_W in-flight tags.

## Configuration
- `RS_AGE_SELECT_EN` defined: per-FU select picks the oldest candidate, i.e. the smallest age relative to `rob_head`.
- Not defined: per-FU select picks the lowest-index candidate, and the age subtractors are removed from select.
- Squash age logic exists in both builds.

## Test plan
- **Reset and ALU dispatch.** Reset, then dispatch ALU tag 3 with both operands ready (5, 7) → `iss_valid[0]=1` next cycle with `iss_v1=5`, `iss_v2=7`, `iss_rob_tag=3`. `free_count` goes 8→7→8 after `iss_ready`.
- **Wakeup.** Dispatch MULT tag 4 with src1 waiting on tag 2. CDB port 1 broadcasts tag 2, value 0xAB two cycles later → issue the cycle after the broadcast with `iss_v1=0xAB`. With `iss_ready=0`, the outputs hold stable.
- **Same-cycle capture.** Dispatch with src2 tag 6 not ready while the CDB carries tag 6, value 9 in the same cycle → issue the next cycle with `iss_v2=9`.
- **Full.** Fill 8 entries with non-ready operands → `dp_ready=0` and `free_count=0`. The 9th `dp_valid` is not accepted.
- **Selective squash.** `rob_head=30`, entries hold tags 30, 31, 0, 1 (wrapped); `squash_tag=31` → tags 0 and 1 are cleared, 30 and 31 remain, and `free_count` rises by 2.
- **Age select.** With `RS_AGE_SELECT_EN` defined, two ready ALU entries with tags 1 (index 5) and 31 (index 0), `rob_head=30` → tag 31 issues first. Without the macro, index 0 (tag 31) also issues first. Swap the indices and the two builds differ.

Source files
------------

// File: rtl/rs_unified.sv
// Unified reservation station: any-FU entries, multi-CDB wakeup, per-FU issue, age-based squash.
// Optional RS_AGE_SELECT_EN: per-FU select picks the oldest candidate instead of the lowest index.
module rs_unified #(
  parameter int NUM_ENTRIES = 8,
  parameter int ENT_IDX_W   = $clog2(NUM_ENTRIES),
  parameter int ROB_TAG_W   = 5,
  parameter int DATA_W      = 32,
  parameter int NUM_CDB     = 2,
  parameter int NUM_FU      = 4,
  parameter int FU_W        = $clog2(NUM_FU),
  parameter int PAYLOAD_W   = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          dp_valid,
  output logic                          dp_ready,
  input  logic [FU_W-1:0]               dp_fu,
  input  logic [ROB_TAG_W-1:0]          dp_rob_tag,
  input  logic [1:0]                    dp_src_ready,
  input  logic [2*ROB_TAG_W-1:0]        dp_src_tag,
  input  logic [2*DATA_W-1:0]           dp_src_value,
  input  logic [PAYLOAD_W-1:0]          dp_payload,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB*ROB_TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]     cdb_value,
  input  logic [ROB_TAG_W-1:0]          rob_head,
  input  logic                          squash_valid,
  input  logic [ROB_TAG_W-1:0]          squash_tag,
  input  logic                          flush_all,
  output logic [NUM_FU-1:0]             iss_valid,
  input  logic [NUM_FU-1:0]             iss_ready,
  output logic [NUM_FU*ROB_TAG_W-1:0]   iss_rob_tag,
  output logic [NUM_FU*DATA_W-1:0]      iss_v1,
  output logic [NUM_FU*DATA_W-1:0]      iss_v2,
  output logic [NUM_FU*PAYLOAD_W-1:0]   iss_payload,
  output logic [ENT_IDX_W:0]            free_count
);

  localparam int N = NUM_ENTRIES;

  logic [N-1:0]                          ent_valid;
  logic [N-1:0][FU_W-1:0]                ent_fu;
  logic [N-1:0][ROB_TAG_W-1:0]           ent_rob_tag;
  logic [N-1:0][1:0]                     ent_rdy;
  logic [N-1:0][1:0][DATA_W-1:0]         ent_val;
  logic [N-1:0][PAYLOAD_W-1:0]           ent_payload;

  logic [NUM_FU-1:0][ENT_IDX_W-1:0]      sel_idx;
  logic [NUM_FU-1:0]                     fire;

  logic                                  alloc_en;
  logic                                  alloc_found;
  logic [ENT_IDX_W-1:0]                  alloc_idx;
  logic [ROB_TAG_W-1:0]                  squash_age;

  always_comb begin
    free_count = '0;
    for (int i = 0; i < N; i++)
      free_count = free_count + {{ENT_IDX_W{1'b0}}, !ent_valid[i]};
  end

  // Lowest free index wins: scan downward so the last hit is the smallest.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = ENT_IDX_W'(i);
      end
    end
  end

  assign dp_ready   = alloc_found && !squash_valid && !flush_all && !reset;
  assign alloc_en   = dp_valid && dp_ready;
  assign squash_age = squash_tag - rob_head;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : gen_entry
      logic                 valid_reg, valid_next;
      logic [FU_W-1:0]      fu_reg, fu_next;
      logic [ROB_TAG_W-1:0] rob_tag_reg, rob_tag_next;
      logic [1:0]           rdy_reg, rdy_next;
      logic [1:0][ROB_TAG_W-1:0] tag_reg, tag_next;
      logic [1:0][DATA_W-1:0]    val_reg, val_next;
      logic [PAYLOAD_W-1:0] payload_reg, payload_next;
      logic [ROB_TAG_W-1:0] ent_age;
      logic                 issue_clr;
      logic                 hit;
      logic [DATA_W-1:0]    hit_val;
      logic [ROB_TAG_W-1:0] want_tag;

      assign ent_age = rob_tag_reg - rob_head;

      always_comb begin
        valid_next   = valid_reg;
        fu_next      = fu_reg;
        rob_tag_next = rob_tag_reg;
        rdy_next     = rdy_reg;
        tag_next     = tag_reg;
        val_next     = val_reg;
        payload_next = payload_reg;
        issue_clr    = 1'b0;
        hit          = 1'b0;
        hit_val      = '0;
        want_tag     = '0;

        for (int f = 0; f < NUM_FU; f++)
          if (fire[f] && sel_idx[f] == ENT_IDX_W'(gi))
            issue_clr = 1'b1;

        if (alloc_en && alloc_idx == ENT_IDX_W'(gi)) begin
          valid_next   = 1'b1;
          fu_next      = dp_fu;
          rob_tag_next = dp_rob_tag;
          payload_next = dp_payload;
          for (int k = 0; k < 2; k++) begin
            want_tag    = dp_src_tag[k*ROB_TAG_W +: ROB_TAG_W];
            tag_next[k] = want_tag;
            hit         = 1'b0;
            hit_val     = '0;
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
              if (cdb_valid[p] && cdb_tag[p*ROB_TAG_W +: ROB_TAG_W] == want_tag) begin
                hit     = 1'b1;
                hit_val = cdb_value[p*DATA_W +: DATA_W];
              end
            end
            if (dp_src_ready[k]) begin
              rdy_next[k] = 1'b1;
              val_next[k] = dp_src_value[k*DATA_W +: DATA_W];
            end else begin
              rdy_next[k] = hit;
              val_next[k] = hit ? hit_val : dp_src_value[k*DATA_W +: DATA_W];
            end
          end
        end else if (valid_reg) begin
          for (int k = 0; k < 2; k++) begin
            hit     = 1'b0;
            hit_val = '0;
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
              if (cdb_valid[p] && cdb_tag[p*ROB_TAG_W +: ROB_TAG_W] == tag_reg[k]) begin
                hit     = 1'b1;
                hit_val = cdb_value[p*DATA_W +: DATA_W];
              end
            end
            if (!rdy_reg[k] && hit) begin
              rdy_next[k] = 1'b1;
              val_next[k] = hit_val;
            end
          end
        end

        // Kills override everything; the branch itself (equal age) survives.
        if (flush_all || (squash_valid && ent_age > squash_age) || issue_clr)
          valid_next = 1'b0;
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          valid_reg   <= 1'b0;
          fu_reg      <= '0;
          rob_tag_reg <= '0;
          rdy_reg     <= '0;
          tag_reg     <= '0;
          val_reg     <= '0;
          payload_reg <= '0;
        end else begin
          valid_reg   <= valid_next;
          fu_reg      <= fu_next;
          rob_tag_reg <= rob_tag_next;
          rdy_reg     <= rdy_next;
          tag_reg     <= tag_next;
          val_reg     <= val_next;
          payload_reg <= payload_next;
        end
      end

      assign ent_valid[gi]   = valid_reg;
      assign ent_fu[gi]      = fu_reg;
      assign ent_rob_tag[gi] = rob_tag_reg;
      assign ent_rdy[gi]     = rdy_reg;
      assign ent_val[gi]     = val_reg;
      assign ent_payload[gi] = payload_reg;
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : gen_fu
      logic [N-1:0]         cand;
      logic [ENT_IDX_W-1:0] pick;
      logic                 hold_valid_reg, hold_valid_next;
      logic [ENT_IDX_W-1:0] hold_idx_reg;

      always_comb begin
        cand = '0;
        for (int i = 0; i < N; i++)
          cand[i] = ent_valid[i] && (ent_fu[i] == FU_W'(gi)) && (&ent_rdy[i]);
      end

`ifdef RS_AGE_SELECT_EN
      logic                 found;
      logic [ROB_TAG_W-1:0] best_age;
      logic [ROB_TAG_W-1:0] cur_age;
      always_comb begin
        found    = 1'b0;
        pick     = '0;
        best_age = '0;
        cur_age  = '0;
        for (int i = 0; i < N; i++) begin
          cur_age = ent_rob_tag[i] - rob_head;
          if (cand[i] && (!found || cur_age < best_age)) begin
            found    = 1'b1;
            pick     = ENT_IDX_W'(i);
            best_age = cur_age;
          end
        end
      end
`else
      always_comb begin
        pick = '0;
        for (int i = N - 1; i >= 0; i--)
          if (cand[i])
            pick = ENT_IDX_W'(i);
      end
`endif

      // A presented entry stays selected until accepted, even if a better candidate wakes up.
      assign sel_idx[gi]     = (hold_valid_reg && cand[hold_idx_reg]) ? hold_idx_reg : pick;
      assign iss_valid[gi]   = |cand;
      assign fire[gi]        = iss_valid[gi] && iss_ready[gi];
      assign hold_valid_next = iss_valid[gi] && !iss_ready[gi] && !flush_all;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          hold_valid_reg <= 1'b0;
          hold_idx_reg   <= '0;
        end else begin
          hold_valid_reg <= hold_valid_next;
          hold_idx_reg   <= sel_idx[gi];
        end
      end

      assign iss_rob_tag[gi*ROB_TAG_W +: ROB_TAG_W] = ent_rob_tag[sel_idx[gi]];
      assign iss_v1[gi*DATA_W +: DATA_W]            = ent_val[sel_idx[gi]][0];
      assign iss_v2[gi*DATA_W +: DATA_W]            = ent_val[sel_idx[gi]][1];
      assign iss_payload[gi*PAYLOAD_W +: PAYLOAD_W] = ent_payload[sel_idx[gi]];
    end
  endgenerate

endmodule
